// File: rtl/rk86_sd_pkg.sv
// rk86_sd_pkg -- shared definitions for the RK86 SD card SPI byte engine.
//   Register offsets in the 0xA000 I/O window, control/status bit positions,
//   the shifter state encoding and the half-period counter width.
package rk86_sd_pkg;

    // CPU register offsets (addr[1:0])
    localparam logic [1:0] REG_CTRL = 2'd0;  // control / status
    localparam logic [1:0] REG_DATA = 2'd1;  // write: send byte, read: rx
    localparam logic [1:0] REG_RECV = 2'd2;  // write: send 0xFF, read: rx
    localparam logic [1:0] REG_NONE = 2'd3;  // unused, reads 0xFF

    // Control / status bit positions
    localparam int CTRL_CS   = 0;
    localparam int CTRL_FAST = 1;
    localparam int STAT_BUSY = 7;

    // Half-period counter width; must hold max(DIV_SLOW, DIV_FAST)
    localparam int HC_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } spi_state_e;

endpackage

// File: rtl/rk86_spi_shifter.sv
// rk86_spi_shifter -- SPI mode 0 byte shifter (MSB first).
//   clk      : system clock
//   reset    : synchronous, active-high
//   start_i  : one-cycle request to send byte_i (ignored unless idle)
//   byte_i   : byte to transmit
//   div_i    : SCK half-period minus 1, latched for the whole byte
//   miso_i   : serial data in, sampled as SCK rises
//   sck_o    : SPI clock, idles low
//   mosi_o   : serial data out, changes as SCK falls, idles high
//   rx_o     : last received byte, updated as busy_o falls
//   busy_o   : transfer in progress
module rk86_spi_shifter
    import rk86_sd_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [7:0]      byte_i,
    input  logic [HC_W-1:0] div_i,
    input  logic            miso_i,
    output logic            sck_o,
    output logic            mosi_o,
    output logic [7:0]      rx_o,
    output logic            busy_o
);

    spi_state_e      state_q;
    logic [7:0]      sr_q;
    logic [2:0]      bitcnt_q;
    logic [HC_W-1:0] hc_q;
    logic [HC_W-1:0] div_q;
    logic            sck_q;
    logic            mosi_q;
    logic [7:0]      rx_q;
    logic            busy_q;

    // NOTE: sequential state uses non-blocking assignments so every branch
    // below reads the values from before the edge (e.g. sr_q[7] in HI is the
    // byte already shifted on the preceding rising SCK edge).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            bitcnt_q <= '0;
            hc_q     <= '0;
            div_q    <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b1;
            rx_q     <= 8'hFF;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        sr_q     <= byte_i;
                        hc_q     <= div_i;
                        div_q    <= div_i;
                        bitcnt_q <= 3'd7;
                        busy_q   <= 1'b1;
                        mosi_q   <= byte_i[7];
                        state_q  <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (hc_q == '0) begin
                        // Rising SCK: capture MISO into the vacated LSB
                        sck_q   <= 1'b1;
                        sr_q    <= {sr_q[6:0], miso_i};
                        hc_q    <= div_q;
                        state_q <= ST_HI;
                    end else begin
                        hc_q <= hc_q - 1'b1;
                    end
                end
                ST_HI: begin
                    if (hc_q == '0) begin
                        sck_q <= 1'b0;
                        if (bitcnt_q == 3'd0) begin
                            state_q <= ST_DONE;
                        end else begin
                            // Falling SCK: present the next bit
                            bitcnt_q <= bitcnt_q - 1'b1;
                            mosi_q   <= sr_q[7];
                            hc_q     <= div_q;
                            state_q  <= ST_LO;
                        end
                    end else begin
                        hc_q <= hc_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    rx_q    <= sr_q;
                    busy_q  <= 1'b0;
                    mosi_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;
    assign rx_o   = rx_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/rk86_sd_spi.sv
// rk86_sd_spi -- CPU-facing SPI byte engine for the RK86 SD card.
//   clk      : system clock (50 MHz)
//   reset    : synchronous, active-high
//   addr     : register offset (CPU address [1:0])
//   we_n     : write strobe (level, may stay low many cycles)
//   rd_n     : read strobe (reads have no side effects)
//   idata    : CPU write data
//   odata    : CPU read data, combinational from addr
//   spi_cs_n : SD chip select
//   spi_sck  : SPI clock
//   spi_mosi : SPI data out
//   spi_miso : SPI data in (DATA0)
//   busy     : transfer in progress
module rk86_sd_spi
    import rk86_sd_pkg::*;
#(
    parameter int DIV_SLOW = 62,
    parameter int DIV_FAST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       we_n,
    input  logic       rd_n,
    input  logic [7:0] idata,
    output logic [7:0] odata,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy
);

    localparam logic [HC_W-1:0] DIV_SLOW_W = HC_W'(DIV_SLOW);
    localparam logic [HC_W-1:0] DIV_FAST_W = HC_W'(DIV_FAST);

    logic            we_prev_q;
    logic            cs_q;
    logic            fast_q;
    logic            wr_acc;
    logic            start;
    logic [7:0]      tx_byte;
    logic [HC_W-1:0] div;
    logic [7:0]      rx;
    logic            unused_rd;

    // Reads are side-effect free, so the read strobe carries no information.
    assign unused_rd = rd_n;

    // One write per falling edge of we_n; anything arriving mid-byte is lost.
    assign wr_acc  = we_prev_q & ~we_n & ~busy;
    assign start   = wr_acc & ((addr == REG_DATA) | (addr == REG_RECV));
    assign tx_byte = (addr == REG_RECV) ? 8'hFF : idata;
    assign div     = fast_q ? DIV_FAST_W : DIV_SLOW_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Treat we_n as already low so a write straddling reset is lost
            we_prev_q <= 1'b0;
            cs_q      <= 1'b0;
            fast_q    <= 1'b0;
        end else begin
            we_prev_q <= we_n;
            if (wr_acc && addr == REG_CTRL) begin
                cs_q   <= idata[CTRL_CS];
                fast_q <= idata[CTRL_FAST];
            end
        end
    end

    rk86_spi_shifter u_shifter (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .byte_i  (tx_byte),
        .div_i   (div),
        .miso_i  (spi_miso),
        .sck_o   (spi_sck),
        .mosi_o  (spi_mosi),
        .rx_o    (rx),
        .busy_o  (busy)
    );

    assign spi_cs_n = ~cs_q;

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        odata = 8'hFF;
        case (addr)
            REG_CTRL: begin
                odata            = '0;
                odata[STAT_BUSY] = busy;
                odata[CTRL_FAST] = fast_q;
                odata[CTRL_CS]   = cs_q;
            end
            REG_DATA, REG_RECV: odata = rx;
            default:            odata = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_rk86_sd_spi.sv
// tb_rk86_sd_spi -- self-checking bench for rk86_sd_spi.
//   A monitor plays the SD card (shifts a response byte out on MISO) and
//   records MOSI bits, SCK pulse widths and busy length; expectations come
//   from the SPI mode 0 rules and the 16*(div+1)+1 busy length.
module tb_rk86_sd_spi;

    localparam int DIV_SLOW = 62;
    localparam int DIV_FAST = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] addr;
    logic       we_n;
    logic       rd_n;
    logic [7:0] idata;
    logic [7:0] odata;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Card model / monitor state
    logic [7:0] miso_resp;
    logic [7:0] mosi_cap;
    int         rise_cnt;
    int         busy_cnt;
    int         hi_run;
    int         hi_min;
    int         hi_max;
    logic       sck_prev;
    logic       cs_n_seen;

    rk86_sd_spi #(.DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .we_n     (we_n),
        .rd_n     (rd_n),
        .idata    (idata),
        .odata    (odata),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: card shifts its response out after each rising SCK
    always @(negedge clk) begin
        if (spi_sck && !sck_prev) begin
            mosi_cap = {mosi_cap[6:0], spi_mosi};
            rise_cnt++;
            spi_miso = (rise_cnt < 8) ? miso_resp[7 - rise_cnt] : 1'b1;
        end
        if (spi_sck) begin
            hi_run++;
        end else if (sck_prev) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
        end
        if (busy) begin
            busy_cnt++;
            if (spi_cs_n) cs_n_seen = 1'b1;
        end
        sck_prev = spi_sck;
    end

    task automatic clear_mon(input logic [7:0] resp);
        miso_resp = resp;
        spi_miso  = resp[7];
        mosi_cap  = '0;
        rise_cnt  = 0;
        busy_cnt  = 0;
        hi_run    = 0;
        hi_min    = 1 << 30;
        hi_max    = 0;
        cs_n_seen = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        addr  = a;
        idata = d;
        we_n  = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        we_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk);
        #1;
        addr = a;
        rd_n = 1'b0;
        @(negedge clk);
        d    = odata;
        rd_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [7:0] rd;

    initial begin
        reset = 1'b1;
        addr  = '0;
        we_n  = 1'b1;
        rd_n  = 1'b1;
        idata = '0;
        sck_prev = 1'b0;
        clear_mon(8'hFF);
        do_reset();

        // 1: reset state
        @(negedge clk);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sck",  32'(spi_sck),  32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd1);
        check("rst_busy", 32'(busy),     32'd0);
        bus_read(2'd0, rd); check("rst_ctrl", 32'(rd), 32'h00);
        bus_read(2'd1, rd); check("rst_rx",   32'(rd), 32'hFF);
        bus_read(2'd3, rd); check("rd_addr3", 32'(rd), 32'hFF);

        // 2: fast transfer 0xA5 out, 0x3C in
        bus_write(2'd0, 8'h03, 1);
        @(negedge clk);
        check("t2_cs_n", 32'(spi_cs_n), 32'd0);
        clear_mon(8'h3C);
        bus_write(2'd1, 8'hA5, 1);
        wait_idle(2000);
        check("t2_mosi",  32'(mosi_cap), 32'hA5);
        check("t2_busy",  32'(busy_cnt), 32'd33);
        check("t2_hi",    32'(hi_max),   32'd2);
        bus_read(2'd1, rd); check("t2_rx", 32'(rd), 32'h3C);

        // 3: slow receive helper, MISO low
        bus_write(2'd0, 8'h01, 1);
        clear_mon(8'h00);
        bus_write(2'd2, 8'h5A, 1);
        wait_idle(2000);
        check("t3_mosi",   32'(mosi_cap), 32'hFF);
        check("t3_rises",  32'(rise_cnt), 32'd8);
        check("t3_hi_min", 32'(hi_min),   32'd63);
        check("t3_hi_max", 32'(hi_max),   32'd63);
        check("t3_busy",   32'(busy_cnt), 32'd1009);
        bus_read(2'd2, rd); check("t3_rx", 32'(rd), 32'h00);

        // 4: long we_n gives one transfer; write while busy is dropped
        bus_write(2'd0, 8'h03, 1);
        clear_mon(8'h81);
        bus_write(2'd1, 8'h55, 28);
        bus_write(2'd1, 8'hAA, 1);
        wait_idle(2000);
        repeat (60) @(negedge clk);
        check("t4_rises", 32'(rise_cnt), 32'd8);
        check("t4_mosi",  32'(mosi_cap), 32'h55);
        check("t4_busy",  32'(busy_cnt), 32'd33);
        bus_read(2'd1, rd); check("t4_rx", 32'(rd), 32'h81);

        // 5: reset at the fourth rising SCK edge
        clear_mon(8'h00);
        bus_write(2'd1, 8'hC3, 1);
        for (int i = 0; i < 200 && rise_cnt < 4; i++) @(negedge clk);
        check("t5_reach", 32'(rise_cnt), 32'd4);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_sck",  32'(spi_sck),  32'd0);
        check("t5_busy", 32'(busy),     32'd0);
        check("t5_cs_n", 32'(spi_cs_n), 32'd1);
        bus_read(2'd1, rd); check("t5_rx",   32'(rd), 32'hFF);
        bus_read(2'd0, rd); check("t5_ctrl", 32'(rd), 32'h00);

        // 6: control write while busy is ignored
        bus_write(2'd0, 8'h03, 1);
        clear_mon(8'h77);
        bus_write(2'd1, 8'h0F, 1);
        bus_write(2'd0, 8'h00, 1);
        bus_read(2'd0, rd); check("t6_stat", 32'(rd), 32'h83);
        wait_idle(2000);
        check("t6_cs_held", 32'(cs_n_seen), 32'd0);
        bus_read(2'd0, rd); check("t6_ctrl", 32'(rd), 32'h03);
        bus_write(2'd0, 8'h00, 1);
        @(negedge clk);
        check("t6_cs_n", 32'(spi_cs_n), 32'd1);

        // Random transfers against the card model
        for (int k = 0; k < 24; k++) begin
            logic       fast;
            logic [1:0] a;
            logic [7:0] tx;
            logic [7:0] resp;
            int         div;
            fast = ($urandom_range(0, 4) != 0);
            a    = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd2;
            tx   = 8'($urandom);
            resp = 8'($urandom);
            div  = fast ? DIV_FAST : DIV_SLOW;
            bus_write(2'd0, {6'b0, fast, 1'b1}, 1);
            bus_read(2'd0, rd);
            check("rnd_ctrl", 32'(rd), 32'({6'b0, fast, 1'b1}));
            clear_mon(resp);
            bus_write(a, tx, $urandom_range(1, 6));
            wait_idle(2000);
            check("rnd_mosi",  32'(mosi_cap), (a == 2'd2) ? 32'hFF : 32'(tx));
            check("rnd_rises", 32'(rise_cnt), 32'd8);
            check("rnd_busy",  32'(busy_cnt), 32'(16 * (div + 1) + 1));
            check("rnd_hi",    32'(hi_max),   32'(div + 1));
            bus_read(a, rd); check("rnd_rx", 32'(rd), 32'(resp));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
